// File: rtl/keyboard_sub_axil_arbiter_if.sv
// AXI4-Lite bus bundle between the Keyboard_Sub arbiter (master) and the
// register-file slave.
interface keyboard_sub_axil_arbiter_if #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
);
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/keyboard_sub_axil_arbiter.sv
// Round-robin arbiter letting two internal clients share one AXI4-Lite master
// port. One transaction is in flight at a time; its response is returned as a
// one-cycle pulse to the client that issued it.
module keyboard_sub_axil_arbiter #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [1:0]                    req_valid,
  input  logic [1:0]                    req_write,
  input  logic [2*C_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*C_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                    req_ready,
  output logic [1:0]                    rsp_valid,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  keyboard_sub_axil_arbiter_if.master   m_axi
);

  localparam int unsigned AW = C_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q;
  logic            grant_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      resp_q;

  logic            accept;
  logic            gnt;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_wdata;
  logic            gnt_write;
  logic            aw_hs;
  logic            w_hs;

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign w_hs  = m_axi.wvalid & m_axi.wready;

  assign gnt_addr  = gnt ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign gnt_wdata = gnt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign gnt_write = gnt ? req_write[1] : req_write[0];

  // Grant selection, next-state decode and request acceptance.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    gnt       = 1'b0;
    req_ready = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (req_valid == 2'b11) begin
          gnt = ~last_grant_q;
        end else begin
          gnt = req_valid[1];
        end
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = gnt_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (m_axi.bvalid) begin
          state_d = StDone;
        end
      end
      StRdReq: begin
        if (m_axi.arready) begin
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (m_axi.rvalid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register, request capture and response latching.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q      <= gnt;
        last_grant_q <= gnt;
        // Registers are word-aligned; byte offset bits are dropped.
        addr_q       <= {gnt_addr[AW-1:2], 2'b00};
        wdata_q      <= gnt_wdata;
        aw_done_q    <= 1'b0;
        w_done_q     <= 1'b0;
        rdata_q      <= '0;
        resp_q       <= 2'b00;
      end
      if (state_q == StWrReq) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (state_q == StWrResp && m_axi.bvalid) begin
        resp_q <= m_axi.bresp;
      end
      if (state_q == StRdResp && m_axi.rvalid) begin
        rdata_q <= m_axi.rdata;
        resp_q  <= m_axi.rresp;
      end
    end
  end

  // AXI outputs come from state and registers only, never from slave inputs.
  always_comb begin
    m_axi.awaddr  = addr_q;
    m_axi.awprot  = 3'b000;
    m_axi.awvalid = (state_q == StWrReq) && !aw_done_q;
    m_axi.wdata   = wdata_q;
    m_axi.wvalid  = (state_q == StWrReq) && !w_done_q;
    // Full-word strobe while W is offered; zero otherwise so reset drives all zeros.
    m_axi.wstrb   = {(DW/8){m_axi.wvalid}};
    m_axi.bready  = (state_q == StWrResp);
    m_axi.araddr  = addr_q;
    m_axi.arprot  = 3'b000;
    m_axi.arvalid = (state_q == StRdReq);
    m_axi.rready  = (state_q == StRdResp);
  end

  // Response pulse to the owning requester.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StDone) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end
    rsp_rdata = rdata_q;
    rsp_resp  = resp_q;
  end

endmodule

// File: tb/tb_keyboard_sub_axil_arbiter.sv
// Directed bench for keyboard_sub_axil_arbiter with a 4-register AXI4-Lite
// slave model that supports AW stalls, B stalls and forced read errors.
module tb_keyboard_sub_axil_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  keyboard_sub_axil_arbiter_if #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) bus ();

  keyboard_sub_axil_arbiter #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_axi     (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] sregs [4];
  logic        have_aw, have_w;
  logic [3:0]  s_awaddr;
  logic [31:0] s_wdata;
  int          aw_cnt;
  int          aw_delay = 0;
  logic        b_hold = 1'b0;
  logic        rd_err = 1'b0;
  logic        aw_now, w_now;
  logic [3:0]  addr_now;
  logic [31:0] data_now;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid;
  assign bus.arready = bus.arvalid;
  assign aw_now   = have_aw || (bus.awvalid && bus.awready);
  assign w_now    = have_w || (bus.wvalid && bus.wready);
  assign addr_now = have_aw ? s_awaddr : bus.awaddr;
  assign data_now = have_w ? s_wdata : bus.wdata;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) sregs[i] <= 32'h0;
      have_aw    <= 1'b0;
      have_w     <= 1'b0;
      s_awaddr   <= 4'h0;
      s_wdata    <= 32'h0;
      aw_cnt     <= 0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rdata  <= 32'h0;
      bus.rresp  <= 2'b00;
    end else begin
      if (bus.awvalid && bus.awready) begin
        have_aw  <= 1'b1;
        s_awaddr <= bus.awaddr;
        aw_cnt   <= 0;
      end else if (bus.awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid && bus.wready) begin
        have_w  <= 1'b1;
        s_wdata <= bus.wdata;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
      end else if (aw_now && w_now && !bus.bvalid && !b_hold) begin
        sregs[addr_now[3:2]] <= data_now;
        bus.bvalid <= 1'b1;
        bus.bresp  <= 2'b00;
        have_aw    <= 1'b0;
        have_w     <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_err ? 32'hDEADBEEF : sregs[bus.araddr[3:2]];
        bus.rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int         cnt_aw = 0, cnt_w = 0, cnt_rsp0 = 0, cnt_rsp1 = 0;
  int         cnt_ready11 = 0, cnt_bready_early = 0, cnt_ar_hs = 0;
  logic [3:0] last_awaddr = 4'h0, last_araddr = 4'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0] last_wstrb = 4'h0;

  always @(negedge ACLK) begin
    if (bus.awvalid) begin
      cnt_aw      <= cnt_aw + 1;
      last_awaddr <= bus.awaddr;
    end
    if (bus.wvalid) begin
      cnt_w      <= cnt_w + 1;
      last_wdata <= bus.wdata;
      last_wstrb <= bus.wstrb;
    end
    if (bus.arvalid) last_araddr <= bus.araddr;
    if (bus.arvalid && bus.arready) cnt_ar_hs <= cnt_ar_hs + 1;
    if (bus.bready && bus.awvalid) cnt_bready_early <= cnt_bready_early + 1;
    if (rsp_valid[0]) cnt_rsp0 <= cnt_rsp0 + 1;
    if (rsp_valid[1]) cnt_rsp1 <= cnt_rsp1 + 1;
    if (req_ready == 2'b11) cnt_ready11 <= cnt_ready11 + 1;
  end

  // ---------------- requester tasks ----------------
  task automatic start_req(input int n, input logic wr, input logic [3:0] a, input logic [31:0] d);
    int k;
    @(posedge ACLK); #1;
    req_valid[n] = 1'b1;
    req_write[n] = wr;
    req_addr[n*AW +: AW] = a;
    req_wdata[n*DW +: DW] = d;
    k = 0;
    @(negedge ACLK);
    while (!req_ready[n] && k < 50) begin
      @(negedge ACLK);
      k++;
    end
    if (k >= 50) check("req_ready_timeout", 64'(k), 64'(0));
    @(posedge ACLK); #1;
    req_valid[n] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output logic [31:0] rd, output logic [1:0] rs, output int lat);
    lat = 1;
    rd = 32'h0;
    rs = 2'b00;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!rsp_valid[n] && lat < 60);
    if (!rsp_valid[n]) check("rsp_timeout", 64'(lat), 64'(0));
    rd = rsp_rdata;
    rs = rsp_resp;
  endtask

  task automatic issue(input int n, input logic wr, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic [1:0] rs, output int lat);
    start_req(n, wr, a, d);
    wait_rsp(n, rd, rs, lat);
  endtask

  task automatic settle();
    repeat (2) @(negedge ACLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;
    int          s_aw, s_w, s_r0, s_r1, s_be, s_ar, s_rdy;
    int          gr [3];
    int          ng;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_outputs", {req_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready,
                            bus.arvalid, bus.rready, bus.wstrb}, 64'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // 1: single write from requester 0
    s_r0 = cnt_rsp0;
    issue(0, 1'b1, 4'h4, 32'h00000002, rd, rs, lat);
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_resp", 64'(rs), 64'd0);
    check("t1_wr_rdata", 64'(rd), 64'd0);
    settle();
    check("t1_awaddr", 64'(last_awaddr), 64'h4);
    check("t1_wdata", 64'(last_wdata), 64'h2);
    check("t1_wstrb", 64'(last_wstrb), 64'hF);
    check("t1_rsp0_pulses", 64'(cnt_rsp0 - s_r0), 64'd1);

    // 2: requester 1 writes and reads back all four registers
    s_r0 = cnt_rsp0;
    s_r1 = cnt_rsp1;
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, 4'(i * 4), 32'(i + 1), rd, rs, lat);
      check("t2_wr_resp", 64'(rs), 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b0, 4'(i * 4), 32'h0, rd, rs, lat);
      check("t2_rd_data", 64'(rd), 64'(i + 1));
      check("t2_rd_lat", 64'(lat), 64'd4);
    end
    // Unaligned byte address falls onto its word register.
    issue(1, 1'b0, 4'hE, 32'h0, rd, rs, lat);
    check("t2_unaligned_data", 64'(rd), 64'd4);
    settle();
    check("t2_unaligned_araddr", 64'(last_araddr), 64'hC);
    check("t2_rsp0_none", 64'(cnt_rsp0 - s_r0), 64'd0);
    check("t2_rsp1_count", 64'(cnt_rsp1 - s_r1), 64'd9);

    // 4: AW held off three cycles, W immediate
    aw_delay = 3;
    s_aw = cnt_aw; s_w = cnt_w; s_be = cnt_bready_early; s_r0 = cnt_rsp0;
    issue(0, 1'b1, 4'h8, 32'h00000055, rd, rs, lat);
    check("t4_lat", 64'(lat), 64'd7);
    settle();
    check("t4_awvalid_cycles", 64'(cnt_aw - s_aw), 64'd4);
    check("t4_wvalid_cycles", 64'(cnt_w - s_w), 64'd1);
    check("t4_bready_early", 64'(cnt_be_delta(s_be)), 64'd0);
    check("t4_rsp_pulses", 64'(cnt_rsp0 - s_r0), 64'd1);
    aw_delay = 0;
    issue(0, 1'b0, 4'h8, 32'h0, rd, rs, lat);
    check("t4_readback", 64'(rd), 64'h55);

    // 5: slave read error passes through, no retry
    rd_err = 1'b1;
    s_ar = cnt_ar_hs;
    issue(0, 1'b0, 4'h0, 32'h0, rd, rs, lat);
    check("t5_rresp", 64'(rs), 64'h2);
    check("t5_rdata", 64'(rd), 64'hDEADBEEF);
    repeat (4) @(negedge ACLK);
    #1;
    check("t5_ar_count", 64'(cnt_ar_hs - s_ar), 64'd1);
    rd_err = 1'b0;

    // 3: contention right after reset -> grants 0, 1, 0
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    s_rdy = cnt_ready11;
    gr[0] = -1; gr[1] = -1; gr[2] = -1;
    ng = 0;
    @(posedge ACLK); #1;
    req_write = 2'b00;
    req_addr  = 8'h40;
    req_valid = 2'b11;
    for (int k = 0; k < 60 && ng < 3; k++) begin
      @(negedge ACLK);
      if (req_ready != 2'b00) begin
        gr[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
    end
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    repeat (6) @(negedge ACLK);
    #1;
    check("t3_grant_count", 64'(ng), 64'd3);
    check("t3_grant0", 64'(gr[0]), 64'd0);
    check("t3_grant1", 64'(gr[1]), 64'd1);
    check("t3_grant2", 64'(gr[2]), 64'd0);
    check("t3_ready_both", 64'(cnt_ready11 - s_rdy), 64'd0);

    // 6: reset while waiting for B aborts the write
    b_hold = 1'b1;
    start_req(0, 1'b1, 4'h4, 32'h12345678);
    lat = 0;
    while (!bus.bready && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    check("t6_reached_wr_resp", 64'(bus.bready), 64'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_async_outputs", {req_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready,
                               bus.arvalid, bus.rready, bus.wstrb}, 64'h0);
    check("t6_async_data", {bus.awaddr, bus.araddr, rsp_resp, rsp_rdata}, 64'h0);
    s_r0 = cnt_rsp0;
    b_hold = 1'b0;
    repeat (3) @(negedge ACLK);
    #2;
    ARESETN = 1'b1;
    settle();
    check("t6_no_rsp", 64'(cnt_rsp0 - s_r0), 64'd0);
    issue(0, 1'b0, 4'h0, 32'h0, rd, rs, lat);
    check("t6_read_lat", 64'(lat), 64'd4);
    check("t6_read_data", 64'(rd), 64'd0);
    check("t6_read_resp", 64'(rs), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  function automatic int cnt_be_delta(input int base);
    return cnt_bready_early - base;
  endfunction

endmodule
